io_input_port: RTL and testbench
================================

// Module: io_input_port
// PURPOSE
//   Producer side of the ALU input operands input_port_data / input_port_kb.
//   Captures keyboard scan bytes from an asynchronous strobe into a small FIFO.
//   Captures data-port bytes via a valid/ready handshake into a one-entry holding register.
//   Presents both to the ALU/CPU datapath with availability flags; the CPU pops them when consumed.
// PARAMETERS
//   WIDTH        8   byte width of kb codes and data-port words
//   KB_DEPTH     4   keyboard FIFO entries; power of 2, >= 2
//   SYNC_STAGES  2   flops in the ext_kb_strobe synchronizer; >= 2
// PORTS
//   clk              in   1                      system clock; all state on rising edge
//   rst_n            in   1                      asynchronous active-low reset
//   ext_kb_strobe    in   1                      async keyboard strobe; rising edge = new code
//   ext_kb_code      in   WIDTH                  keyboard code; stable while strobe high
//   ext_data_valid   in   1                      data-port source has a word
//   ext_data         in   WIDTH                  data-port word
//   ext_data_ready   out  1                      holding register empty, transfer accepted
//   cpu_kb_pop       in   1                      CPU consumed FIFO head
//   cpu_data_pop     in   1                      CPU consumed data word
//   cpu_ovf_clr      in   1                      clears kb_overflow
//   input_port_kb    out  WIDTH                  FIFO head (show-ahead); 0 when empty
//   input_port_data  out  WIDTH                  holding register contents
//   kb_avail         out  1                      FIFO not empty
//   data_avail       out  1                      holding register full
//   kb_count         out  $clog2(KB_DEPTH+1)     FIFO occupancy
//   kb_overflow      out  1                      sticky: code dropped because FIFO was full
// BEHAVIOUR
//   Reset (async, rst_n=0): all outputs 0 except ext_data_ready=1.
//     Clears the sync chain, pointers, count, holding register and overflow flag.
//   KB capture:
//     - ext_kb_strobe passes through SYNC_STAGES flops; an edge register detects 0->1.
//     - On the detect cycle, ext_kb_code is written at wr_ptr.
//     - Push-to-kb_avail latency: SYNC_STAGES+1 clk after the strobe rise is sampled.
//     - A strobe held high through reset release counts as one push.
//     - One push per rising edge; a strobe held high pushes only once.
//   KB pop:
//     - cpu_kb_pop with kb_avail: rd_ptr advances and count decrements.
//     - The next head shows on input_port_kb in the following cycle.
//     - Pop while empty is ignored; no underflow and no flag.
//   FIFO boundaries:
//     - Pointers are log2(KB_DEPTH) bits and wrap modulo KB_DEPTH.
//     - Push while full with no pop: the code is dropped, the FIFO is unchanged, kb_overflow<=1.
//     - Push and pop in the same cycle: both occur, count unchanged, never an overflow even when full.
//     - Push and pop in the same cycle when empty: only the push occurs.
//     - kb_overflow stays set until cpu_ovf_clr.
//     - If cpu_ovf_clr and an overflow coincide, set wins.
//   Data port:
//     - ext_data_ready = ~data_avail (registered state, no combinational path from inputs).
//     - ext_data_valid & ext_data_ready: load ext_data and set data_avail on that edge.
//     - cpu_data_pop clears data_avail; input_port_data keeps its last value.
//     - Pop with valid in the same cycle while full: pop only; the new word transfers next cycle.
//     - Maximum data-port throughput: one word per 2 clk.
//   Mid-operation reset discards FIFO contents and any held word immediately.
// CONFIGURATION
//   INPORT_IRQ_EN defined:
//     - Adds output irq (1 bit), a registered level = kb_avail | data_avail | kb_overflow.
//     - Reset 0; irq follows its sources with 1 clk lag.
//   INPORT_IRQ_EN undefined:
//     - No irq port and no irq logic; all other behaviour is identical.
// TESTING
//   1. Reset: hold rst_n=0 with random inputs.
//      -> all outputs 0, ext_data_ready=1, kb_count=0.
//   2. KB single: strobe rise with code 8'h1C.
//      -> kb_avail=1 and input_port_kb=8'h1C after 3 clk; pop -> kb_avail=0, input_port_kb=0.
//   3. KB overflow: push 8'h01..8'h05 with KB_DEPTH=4.
//      -> kb_count=4, kb_overflow=1, pops return 01,02,03,04 in order; cpu_ovf_clr -> 0.
//   4. Full push+pop: FIFO full, a detect cycle coincides with cpu_kb_pop.
//      -> kb_count stays 4, kb_overflow=0, wrap order preserved.
//   5. Data handshake: valid with 8'hA5 while empty -> data_avail=1, ready=0.
//      Second valid 8'h3C is held off until pop; then input_port_data=8'h3C.
//   6. Reset mid-burst: assert rst_n=0 with 3 queued codes and a held word.
//      -> kb_count=0, data_avail=0, and irq=0 when INPORT_IRQ_EN is defined.

Source files
------------

// File: rtl/io_input_port_if.sv
// +----------------------------------------------------------------------------+
// | io_input_port_if                                                           |
// | Bus bundle for io_input_port: keyboard/data-port sources and CPU side.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface io_input_port_if #(
    parameter int WIDTH    = 8,
    parameter int KB_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(KB_DEPTH + 1);

    logic               ext_kb_strobe;
    logic [WIDTH-1:0]   ext_kb_code;
    logic               ext_data_valid;
    logic [WIDTH-1:0]   ext_data;
    logic               ext_data_ready;
    logic               cpu_kb_pop;
    logic               cpu_data_pop;
    logic               cpu_ovf_clr;
    logic [WIDTH-1:0]   input_port_kb;
    logic [WIDTH-1:0]   input_port_data;
    logic               kb_avail;
    logic               data_avail;
    logic [c_CNT_W-1:0] kb_count;
    logic               kb_overflow;

    modport master (
        input  ext_kb_strobe, ext_kb_code, ext_data_valid, ext_data,
               cpu_kb_pop, cpu_data_pop, cpu_ovf_clr,
        output ext_data_ready, input_port_kb, input_port_data,
               kb_avail, data_avail, kb_count, kb_overflow
    );

    modport slave (
        output ext_kb_strobe, ext_kb_code, ext_data_valid, ext_data,
               cpu_kb_pop, cpu_data_pop, cpu_ovf_clr,
        input  ext_data_ready, input_port_kb, input_port_data,
               kb_avail, data_avail, kb_count, kb_overflow
    );
endinterface

`default_nettype wire

// File: rtl/io_input_port.sv
// +----------------------------------------------------------------------------+
// | io_input_port                                                              |
// | Keyboard strobe FIFO plus one-entry data-port holding register feeding the |
// | ALU input operands. Define INPORT_IRQ_EN to add the registered irq output. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module io_input_port #(
    parameter int WIDTH       = 8,
    parameter int KB_DEPTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
`ifdef INPORT_IRQ_EN
    output logic            irq,
`endif
    io_input_port_if.master bus
);
    localparam int                 c_PTR_W = $clog2(KB_DEPTH);
    localparam int                 c_CNT_W = $clog2(KB_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(KB_DEPTH);

    logic [SYNC_STAGES-1:0] r_kb_sync;
    logic                   r_kb_prev;
    logic [WIDTH-1:0]       r_mem [KB_DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_overflow;
    logic                   r_data_avail;
    logic [WIDTH-1:0]       r_data;

    logic w_detect;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_data_load;

    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign w_detect    = r_kb_sync[SYNC_STAGES-1] & ~r_kb_prev;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL);
    assign w_pop       = bus.cpu_kb_pop & ~w_empty;
    assign w_push      = w_detect & (~w_full | w_pop);
    assign w_drop      = w_detect & w_full & ~w_pop;
    assign w_data_load = bus.ext_data_valid & ~r_data_avail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kb_sync <= '0;
            r_kb_prev <= 1'b0;
        end else begin
            r_kb_sync <= {r_kb_sync[SYNC_STAGES-2:0], bus.ext_kb_strobe};
            r_kb_prev <= r_kb_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)               r_overflow <= 1'b1;
            else if (bus.cpu_ovf_clr) r_overflow <= 1'b0;
        end
    end

    // Storage needs no reset: an empty FIFO forces the head output to zero.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.ext_kb_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_avail <= 1'b0;
            r_data       <= '0;
        end else if (w_data_load) begin
            r_data_avail <= 1'b1;
            r_data       <= bus.ext_data;
        end else if (bus.cpu_data_pop) begin
            r_data_avail <= 1'b0;
        end
    end

    assign bus.input_port_kb   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.input_port_data = r_data;
    assign bus.kb_avail        = ~w_empty;
    assign bus.data_avail      = r_data_avail;
    assign bus.ext_data_ready  = ~r_data_avail;
    assign bus.kb_count        = r_count;
    assign bus.kb_overflow     = r_overflow;

`ifdef INPORT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= ~w_empty | r_data_avail | r_overflow;
    end

    assign irq = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_input_port.sv
// +----------------------------------------------------------------------------+
// | tb_io_input_port                                                           |
// | Directed bench with a queue-based reference model for io_input_port.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_io_input_port;
    localparam int WIDTH       = 8;
    localparam int KB_DEPTH    = 4;
    localparam int SYNC_STAGES = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    io_input_port_if #(.WIDTH(WIDTH), .KB_DEPTH(KB_DEPTH)) bus ();
`ifdef INPORT_IRQ_EN
    logic irq;
`endif

    io_input_port #(
        .WIDTH      (WIDTH),
        .KB_DEPTH   (KB_DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef INPORT_IRQ_EN
        .irq  (irq),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, holding register as value+flag.
    // m_hist[i] is the strobe level seen i edges ago; a push lands once a
    // sampled rise has aged SYNC_STAGES edges.
    logic [7:0]             m_q[$];
    logic                   m_ovf    = 1'b0;
    logic                   m_davail = 1'b0;
    logic [7:0]             m_data   = 8'h00;
    logic                   m_irq    = 1'b0;
    logic [SYNC_STAGES+1:0] m_hist   = '0;
    logic                   m_push, m_pop, m_drop;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_davail = 1'b0;
            m_data   = 8'h00;
            m_irq    = 1'b0;
            m_hist   = '0;
        end else begin
            m_irq  = (m_q.size() != 0) || m_davail || m_ovf;
            m_hist = {m_hist[SYNC_STAGES:0], bus.ext_kb_strobe};
            m_push = m_hist[SYNC_STAGES] && !m_hist[SYNC_STAGES+1];
            m_pop  = bus.cpu_kb_pop && (m_q.size() > 0);
            m_drop = m_push && (m_q.size() == KB_DEPTH) && !m_pop;
            if (m_pop) void'(m_q.pop_front());
            if (m_push && !m_drop) m_q.push_back(bus.ext_kb_code);
            if (m_drop) m_ovf = 1'b1;
            else if (bus.cpu_ovf_clr) m_ovf = 1'b0;
            if (bus.ext_data_valid && !m_davail) begin
                m_data   = bus.ext_data;
                m_davail = 1'b1;
            end else if (bus.cpu_data_pop) begin
                m_davail = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #3;
        check("cyc_kb_count", 32'(bus.kb_count), 32'(m_q.size()));
        check("cyc_kb_avail", 32'(bus.kb_avail), 32'(m_q.size() != 0));
        check("cyc_kb_head", 32'(bus.input_port_kb), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
        check("cyc_kb_overflow", 32'(bus.kb_overflow), 32'(m_ovf));
        check("cyc_data_avail", 32'(bus.data_avail), 32'(m_davail));
        check("cyc_data_ready", 32'(bus.ext_data_ready), 32'(!m_davail));
        check("cyc_data", 32'(bus.input_port_data), 32'(m_data));
`ifdef INPORT_IRQ_EN
        check("cyc_irq", 32'(irq), 32'(m_irq));
`endif
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the strobe with a new code, hold it past detection, then let the
    // synchronizer see it low again before the next rise.
    task automatic kb_push(input logic [7:0] code);
        @(negedge clk);
        bus.ext_kb_strobe = 1'b1;
        bus.ext_kb_code   = code;
        idle(4);
        bus.ext_kb_strobe = 1'b0;
        idle(3);
    endtask

    task automatic kb_pop_expect(input string name, input logic [7:0] code);
        check(name, 32'(bus.input_port_kb), 32'(code));
        bus.cpu_kb_pop = 1'b1;
        @(negedge clk);
        bus.cpu_kb_pop = 1'b0;
    endtask

    initial begin
        bus.ext_kb_strobe  = 1'b0;
        bus.ext_kb_code    = '0;
        bus.ext_data_valid = 1'b0;
        bus.ext_data       = '0;
        bus.cpu_kb_pop     = 1'b0;
        bus.cpu_data_pop   = 1'b0;
        bus.cpu_ovf_clr    = 1'b0;
        #1 rst_n = 1'b0;

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            bus.ext_kb_strobe  = 1'($urandom);
            bus.ext_kb_code    = 8'($urandom);
            bus.ext_data_valid = 1'($urandom);
            bus.ext_data       = 8'($urandom);
            bus.cpu_kb_pop     = 1'($urandom);
            bus.cpu_data_pop   = 1'($urandom);
            bus.cpu_ovf_clr    = 1'($urandom);
        end
        @(negedge clk);
        check("rst_kb_count", 32'(bus.kb_count), 32'h0);
        check("rst_kb_avail", 32'(bus.kb_avail), 32'h0);
        check("rst_data_avail", 32'(bus.data_avail), 32'h0);
        check("rst_ready", 32'(bus.ext_data_ready), 32'h1);
        check("rst_kb_head", 32'(bus.input_port_kb), 32'h0);
        check("rst_data", 32'(bus.input_port_data), 32'h0);
        check("rst_overflow", 32'(bus.kb_overflow), 32'h0);
`ifdef INPORT_IRQ_EN
        check("rst_irq", 32'(irq), 32'h0);
`endif
        bus.ext_kb_strobe  = 1'b0;
        bus.ext_kb_code    = '0;
        bus.ext_data_valid = 1'b0;
        bus.ext_data       = '0;
        bus.cpu_kb_pop     = 1'b0;
        bus.cpu_data_pop   = 1'b0;
        bus.cpu_ovf_clr    = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single keyboard code: visible on the third edge after the rise
        @(negedge clk);
        bus.ext_kb_strobe = 1'b1;
        bus.ext_kb_code   = 8'h1C;
        repeat (2) @(posedge clk);
        #2 check("kb1_not_yet", 32'(bus.kb_avail), 32'h0);
        @(posedge clk);
        #2 check("kb1_avail", 32'(bus.kb_avail), 32'h1);
        check("kb1_head", 32'(bus.input_port_kb), 32'h1C);
        @(negedge clk);
        bus.ext_kb_strobe = 1'b0;
        bus.cpu_kb_pop    = 1'b1;
        @(negedge clk);
        bus.cpu_kb_pop = 1'b0;
        check("kb1_pop_avail", 32'(bus.kb_avail), 32'h0);
        check("kb1_pop_head", 32'(bus.input_port_kb), 32'h0);
        idle(4);

        // Pop while empty is ignored
        bus.cpu_kb_pop = 1'b1;
        @(negedge clk);
        bus.cpu_kb_pop = 1'b0;
        check("empty_pop_count", 32'(bus.kb_count), 32'h0);
        check("empty_pop_ovf", 32'(bus.kb_overflow), 32'h0);

        // Overflow: five codes into four slots
        for (int i = 1; i <= 5; i++) kb_push(8'(i));
        check("ovf_count", 32'(bus.kb_count), 32'h4);
        check("ovf_flag", 32'(bus.kb_overflow), 32'h1);
        for (int i = 1; i <= 4; i++) kb_pop_expect("ovf_order", 8'(i));
        check("ovf_drained", 32'(bus.kb_avail), 32'h0);
        check("ovf_sticky", 32'(bus.kb_overflow), 32'h1);
        bus.cpu_ovf_clr = 1'b1;
        @(negedge clk);
        bus.cpu_ovf_clr = 1'b0;
        check("ovf_cleared", 32'(bus.kb_overflow), 32'h0);

        // Full FIFO: detect cycle coincides with a pop
        for (int i = 0; i < 4; i++) kb_push(8'h11 + 8'(i));
        check("full_count", 32'(bus.kb_count), 32'h4);
        @(negedge clk);
        bus.ext_kb_strobe = 1'b1;
        bus.ext_kb_code   = 8'h15;
        idle(2);
        bus.cpu_kb_pop = 1'b1;
        @(negedge clk);
        bus.cpu_kb_pop = 1'b0;
        check("pp_count", 32'(bus.kb_count), 32'h4);
        check("pp_no_ovf", 32'(bus.kb_overflow), 32'h0);
        idle(2);
        bus.ext_kb_strobe = 1'b0;
        idle(3);
        for (int i = 0; i < 4; i++) kb_pop_expect("pp_wrap_order", 8'h12 + 8'(i));
        check("pp_drained", 32'(bus.kb_count), 32'h0);

        // Data-port handshake
        @(negedge clk);
        bus.ext_data_valid = 1'b1;
        bus.ext_data       = 8'hA5;
        @(negedge clk);
        bus.ext_data = 8'h3C;
        check("dp_avail", 32'(bus.data_avail), 32'h1);
        check("dp_ready", 32'(bus.ext_data_ready), 32'h0);
        check("dp_word", 32'(bus.input_port_data), 32'hA5);
        idle(2);
        check("dp_held_off", 32'(bus.input_port_data), 32'hA5);
`ifdef INPORT_IRQ_EN
        check("dp_irq", 32'(irq), 32'h1);
`endif
        bus.cpu_data_pop = 1'b1;
        @(negedge clk);
        bus.cpu_data_pop = 1'b0;
        check("dp_pop_avail", 32'(bus.data_avail), 32'h0);
        check("dp_pop_keep", 32'(bus.input_port_data), 32'hA5);
        @(negedge clk);
        check("dp_second", 32'(bus.input_port_data), 32'h3C);
        check("dp_second_avail", 32'(bus.data_avail), 32'h1);
        bus.ext_data_valid = 1'b0;
        bus.cpu_data_pop   = 1'b1;
        @(negedge clk);
        bus.cpu_data_pop = 1'b0;
        idle(2);

        // Mid-operation reset with queued codes and a held word
        kb_push(8'h21);
        kb_push(8'h22);
        kb_push(8'h23);
        bus.ext_data_valid = 1'b1;
        bus.ext_data       = 8'hAB;
        @(negedge clk);
        bus.ext_data_valid = 1'b0;
        check("mr_count_pre", 32'(bus.kb_count), 32'h3);
        check("mr_avail_pre", 32'(bus.data_avail), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_count", 32'(bus.kb_count), 32'h0);
        check("mr_data_avail", 32'(bus.data_avail), 32'h0);
        check("mr_ready", 32'(bus.ext_data_ready), 32'h1);
`ifdef INPORT_IRQ_EN
        check("mr_irq", 32'(irq), 32'h0);
`endif
        // Strobe held high through release counts exactly once
        bus.ext_kb_strobe = 1'b1;
        bus.ext_kb_code   = 8'h5A;
        idle(3);
        rst_n = 1'b1;
        idle(8);
        check("hold_count", 32'(bus.kb_count), 32'h1);
        check("hold_head", 32'(bus.input_port_kb), 32'h5A);
        bus.ext_kb_strobe = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
